// File: rtl/data_mem_dump.sv
// End-of-run data-memory readback: streams N_WORDS {addr,data} from BASE_ADDR, else passes the DUT port through.
// Latency: first out_valid 2 cycles after start, then one word per cycle while out_ready is held high.
// Backpressure: out_ready low holds the head word; reads stop once FIFO plus in-flight reach 2 (MEM_DUMP_CHECKSUM_EN adds chk_sum/chk_valid).

module mem_dump_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_vld,
    input  logic [WIDTH-1:0]           in_dat,
    output logic                       out_vld,
    output logic [WIDTH-1:0]           out_dat,
    input  logic                       out_rdy,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] slot [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign out_vld = (count != '0);
    assign out_dat = slot[rd_ptr];
    assign pop     = out_vld && out_rdy;
    // A push into a full FIFO is dropped unless a pop frees a slot the same cycle.
    assign push    = in_vld && ((count != CW'(DEPTH)) || pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot[i] <= '0;
            end
        end else begin
            if (push) begin
                slot[wr_ptr] <= in_dat;
                wr_ptr       <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

module data_mem_dump #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h10010000,
    parameter int                N_WORDS   = 256
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              dut_rd,
    input  logic              dut_wr,
    input  logic [ADDR_W-1:0] dut_addr,
    input  logic [DATA_W-1:0] dut_wdata,
    output logic [DATA_W-1:0] dut_rdata,
    output logic              dut_conflict,
    output logic              mem_rd,
    output logic              mem_wr_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data
`ifdef MEM_DUMP_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] chk_sum,
    output logic              chk_valid
`endif
);
    localparam int CW = $clog2(N_WORDS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [CW-1:0]        issue_cnt;
    logic                 in_flight;
    logic [ADDR_W-1:0]    flight_addr;
    logic [ADDR_W-1:0]    eng_addr;
    logic                 eng_rd;
    logic                 pop;
    logic                 credit_ok;
    logic                 last_issue;
    logic [2:0]           occ;
    logic [1:0]           fifo_count;
    logic [ADDR_W+DATA_W-1:0] head;

    assign eng_addr   = BASE_ADDR + (ADDR_W'(issue_cnt) << 2);
    assign last_issue = (issue_cnt == CW'(N_WORDS - 1));
    assign pop        = out_valid && out_ready;
    // A pop in the same cycle frees a slot, which keeps one word per cycle flowing.
    assign occ        = 3'(fifo_count) + 3'(in_flight) - 3'(pop);
    assign credit_ok  = (occ < 3'd2);

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        eng_rd   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_READ;
                end
            end
            S_READ: begin
                eng_rd = credit_ok;
                if (credit_ok && last_issue) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && (fifo_count == 2'd1) && !in_flight) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            issue_cnt    <= '0;
            in_flight    <= 1'b0;
            flight_addr  <= '0;
            dut_conflict <= 1'b0;
        end else begin
            in_flight   <= eng_rd;
            flight_addr <= eng_addr;
            if ((state == S_IDLE) && start) begin
                issue_cnt <= '0;
            end else if (eng_rd) begin
                issue_cnt <= issue_cnt + 1'b1;
            end
            if (busy && (dut_rd || dut_wr)) begin
                dut_conflict <= 1'b1;
            end
        end
    end

    // While busy the DUT is cut off: no writes reach memory and reads return zero.
    assign mem_rd    = busy ? eng_rd   : dut_rd;
    assign mem_wr_n  = busy ? 1'b1     : ~dut_wr;
    assign mem_addr  = busy ? eng_addr : dut_addr;
    assign mem_wdata = busy ? '0       : dut_wdata;
    assign dut_rdata = busy ? '0       : mem_rdata;

    mem_dump_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (2)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RST_n),
        .in_vld  (in_flight),
        .in_dat  ({flight_addr, mem_rdata}),
        .out_vld (out_valid),
        .out_dat (head),
        .out_rdy (out_ready),
        .count   (fifo_count)
    );

    assign out_addr = head[DATA_W +: ADDR_W];
    assign out_data = head[DATA_W-1:0];

`ifdef MEM_DUMP_CHECKSUM_EN
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            chk_sum <= '0;
        end else if ((state == S_IDLE) && start) begin
            chk_sum <= '0;
        end else if (pop) begin
            chk_sum <= chk_sum + out_data;
        end
    end

    assign chk_valid = done;
`endif
endmodule

// File: tb/tb_data_mem_dump.sv
// Randomised bench for data_mem_dump: behavioural memory, expected-word queue and a per-cycle monitor.
module tb_data_mem_dump;
    localparam logic [31:0] BASE = 32'h10010000;
    localparam int          N    = 256;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic        dut_rd = 1'b0;
    logic        dut_wr = 1'b0;
    logic [31:0] dut_addr = '0;
    logic [31:0] dut_wdata = '0;
    logic [31:0] dut_rdata;
    logic        dut_conflict;
    logic        mem_rd;
    logic        mem_wr_n;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_addr;
    logic [31:0] out_data;
`ifdef MEM_DUMP_CHECKSUM_EN
    logic [31:0] chk_sum;
    logic        chk_valid;
`endif

    data_mem_dump dut (
        .CLK          (CLK),
        .RST_n        (RST_n),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .dut_rd       (dut_rd),
        .dut_wr       (dut_wr),
        .dut_addr     (dut_addr),
        .dut_wdata    (dut_wdata),
        .dut_rdata    (dut_rdata),
        .dut_conflict (dut_conflict),
        .mem_rd       (mem_rd),
        .mem_wr_n     (mem_wr_n),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_addr     (out_addr),
        .out_data     (out_data)
`ifdef MEM_DUMP_CHECKSUM_EN
        ,
        .chk_sum      (chk_sum),
        .chk_valid    (chk_valid)
`endif
    );

    always #5 CLK = ~CLK;

    logic [31:0] mem_arr [logic [31:0]];

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return a ^ 32'h5A5A_5A5A;
    endfunction

    // Synchronous memory with one cycle of read latency.
    always @(posedge CLK) begin
        if (mem_rd) mem_rdata <= rd_word(mem_addr);
        if (!mem_wr_n) mem_arr[mem_addr] = mem_wdata;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [63:0] exp_q [$];
    int          issued = 0;
    int          acc = 0;
    bit          m_busy = 1'b0;
    bit          m_conf = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_a = '0;
    logic [31:0] prev_d = '0;
    bit          mon_en = 1'b0;

    task automatic fill(input int mode);
        for (int i = 0; i < N; i++) begin
            mem_arr[BASE + 32'(4 * i)] = (mode == 0) ? 32'(i) : $urandom;
        end
    endtask

    // Samples at the falling edge, then advances the model across the next rising edge.
    task automatic tick();
        bit          hs;
        bit          exp_done;
        int          outst;
        logic [63:0] front;
        @(negedge CLK);
        if (mon_en) begin
            if (!RST_n) begin
                exp_q.delete();
                issued = 0;
                acc = 0;
                m_busy = 1'b0;
                m_conf = 1'b0;
                prev_stall = 1'b0;
            end else begin
                hs = out_valid && out_ready;
                outst = issued - acc;
                exp_done = m_busy && (acc == N);
                check("busy", 128'(busy), 128'(m_busy));
                check("done", 128'(done), 128'(exp_done));
                check("conflict", 128'(dut_conflict), 128'(m_conf));
                if (m_busy) begin
                    check("mux_owned", 128'({mem_wr_n, mem_wdata, dut_rdata}), 128'({1'b1, 32'h0, 32'h0}));
                    if (!hs && outst == 2) check("credit_stall", 128'(mem_rd), 128'(0));
                    if (mem_rd) begin
                        check("issue_addr", 128'(mem_addr), 128'(BASE + 32'(4 * issued)));
                        check("credit", 128'((outst + 1 - int'(hs)) <= 2 && issued < N), 128'(1));
                    end
                    if (prev_stall) check("stall_hold", 128'({out_valid, out_addr, out_data}), 128'({1'b1, prev_a, prev_d}));
                    if (hs) begin
                        if (exp_q.size() == 0) begin
                            check("extra_word", 128'(exp_q.size()), 128'(1));
                        end else begin
                            front = exp_q.pop_front();
                            check("sink_word", 128'({out_addr, out_data}), 128'(front));
                        end
                        acc++;
                    end
                    if (mem_rd) issued++;
                    if (dut_rd || dut_wr) m_conf = 1'b1;
                end else begin
                    check("passthru", 128'({mem_rd, mem_wr_n, mem_addr, mem_wdata, dut_rdata}),
                          128'({dut_rd, ~dut_wr, dut_addr, dut_wdata, mem_rdata}));
                    check("idle_valid", 128'(out_valid), 128'(0));
                end
                prev_stall = m_busy && out_valid && !out_ready;
                prev_a = out_addr;
                prev_d = out_data;
                if (exp_done) begin
                    m_busy = 1'b0;
                end else if (!m_busy && start) begin
                    m_busy = 1'b1;
                    issued = 0;
                    acc = 0;
                    exp_q.delete();
                    for (int i = 0; i < N; i++) begin
                        exp_q.push_back({BASE + 32'(4 * i), rd_word(BASE + 32'(4 * i))});
                    end
                end
            end
        end
        @(posedge CLK);
        #1;
    endtask

    // mode 0: ready always 1; 1: ready pattern 1,0,0,1; 2: random ready.
    task automatic run_dump(input int mode, input int restart_at, input int conf_lo, input int conf_hi,
                            input int abort_at, output int first_v, output int done_cyc);
        int  cyc;
        bit  seen_done;
        bit  aborted;
        first_v = -1;
        done_cyc = -1;
        seen_done = 1'b0;
        aborted = 1'b0;
        cyc = 0;
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (!seen_done && cyc < 3000) begin
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            start = (cyc == restart_at);
            dut_rd = (cyc >= conf_lo) && (cyc < conf_hi);
            dut_wr = dut_rd && cyc[0];
            dut_addr = $urandom;
            dut_wdata = $urandom;
            if (abort_at >= 0 && acc == abort_at) begin
                RST_n = 1'b0;
                tick();
                RST_n = 1'b1;
                aborted = 1'b1;
                break;
            end
            tick();
            cyc++;
            if (out_valid && first_v < 0) first_v = cyc;
            if (done) begin
                seen_done = 1'b1;
                done_cyc = cyc;
            end
        end
        start = 1'b0;
        dut_rd = 1'b0;
        dut_wr = 1'b0;
        if (!seen_done && !aborted) check("dump_timeout", 128'(seen_done), 128'(1));
    endtask

    int fv;
    int dc;

    initial begin
        RST_n = 1'b0;
        tick();
        tick();
        check("rst_outputs", 128'({busy, done, out_valid, dut_conflict, out_addr, out_data}), 128'(0));
        RST_n = 1'b1;
        mon_en = 1'b1;

        // Passthrough write then read back through the DUT port.
        dut_wr = 1'b1;
        dut_addr = 32'h10010008;
        dut_wdata = 32'hDEADBEEF;
        #1;
        check("pt_write", 128'({mem_wr_n, mem_addr, mem_wdata}), 128'({1'b0, 32'h10010008, 32'hDEADBEEF}));
        tick();
        dut_wr = 1'b0;
        dut_rd = 1'b1;
        tick();
        check("pt_read", 128'(dut_rdata), 128'(32'hDEADBEEF));
        dut_rd = 1'b0;
        tick();

        // Full dump, sink always ready, mem[i] = i.
        fill(0);
        run_dump(0, -1, -1, -1, -1, fv, dc);
        check("first_valid_cyc", 128'(fv), 128'(2));
        check("done_cyc", 128'(dc), 128'(258));
`ifdef MEM_DUMP_CHECKSUM_EN
        check("chk_sum", 128'({chk_valid, chk_sum}), 128'({1'b1, 32'h00007F80}));
`endif
        tick();
        check("done_pulse", 128'({done, busy}), 128'(0));
        check("full_words", 128'(acc), 128'(N));

        // Backpressure pattern with a start pulse while busy.
        fill(1);
        run_dump(1, 40, -1, -1, -1, fv, dc);
        check("bp_words", 128'(acc), 128'(N));
        tick();

        // DUT access during a dump, random sink readiness.
        fill(1);
        run_dump(2, -1, 10, 16, -1, fv, dc);
        check("rnd_words", 128'(acc), 128'(N));
        tick();
        tick();
        check("conflict_sticky", 128'(dut_conflict), 128'(1));

        // Reset after 100 words, then a clean restart.
        run_dump(0, -1, -1, -1, 100, fv, dc);
        check("abort_state", 128'({busy, out_valid, done, dut_conflict}), 128'(0));
        for (int i = 0; i < 20; i++) begin
            dut_rd = 1'($urandom_range(0, 1));
            dut_addr = $urandom;
            tick();
        end
        dut_rd = 1'b0;
        fill(1);
        run_dump(2, -1, -1, -1, -1, fv, dc);
        check("restart_words", 128'(acc), 128'(N));
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
